// File: rtl/prog_loader.sv
// Byte-serial instruction memory loader: takes a framed stream (length, word
// bytes high-first, XOR checksum) and writes 16-bit words at consecutive addresses.
module prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              im_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = byte_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          chk_d   = 8'h00;
          addr_d  = BASE_ADDR;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (byte_in == 8'h00) begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            cnt_d   = byte_in;
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = byte_in;
          chk_d   = chk_q ^ byte_in;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          wdata_d = {hi_q, byte_in};
          chk_d   = chk_q ^ byte_in;
          we_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The strobe is live this cycle; advance address/count for the next word.
        cnt_d   = cnt_q - 8'd1;
        addr_d  = addr_q + 1'b1;
        state_d = (cnt_q == 8'd1) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (accept) begin
          busy_d = 1'b0;
          if (byte_in == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
              (state_d == S_LO)  || (state_d == S_CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chk_q   <= '0;
      hi_q    <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready = ready_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign im_we      = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0x00 and 0xFE) fed the same stream,
// frames from a table, writes checked against per-instance expectation queues.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_in;

  logic        byte_ready0, im_we0, busy0, done0, err0;
  logic [7:0]  im_addr0;
  logic [15:0] im_wdata0;
  logic        byte_ready1, im_we1, busy1, done1, err1;
  logic [7:0]  im_addr1;
  logic [15:0] im_wdata1;

  prog_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready0), .im_addr(im_addr0), .im_wdata(im_wdata0), .im_we(im_we0),
    .busy(busy0), .done(done0), .err(err0));

  prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready1), .im_addr(im_addr1), .im_wdata(im_wdata1), .im_we(im_we1),
    .busy(busy1), .done(done1), .err(err1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp0[$];
  logic [23:0] exp1[$];
  logic [23:0] e0, e1;

  typedef struct {
    logic [7:0]        n;
    logic [3:0][15:0]  words;
    logic [7:0]        csum;
    int                mode;      // 0 burst, 1 alternate gaps, 2 random gaps
    bit                mid_start;
    bit                exp_done;
  } frame_t;

  frame_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (im_we0) begin
      if (exp0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_write: got addr %0h data %0h expected no write", im_addr0, im_wdata0);
      end else begin
        e0 = exp0.pop_front();
        check("dut0_write", {8'h00, im_addr0, im_wdata0}, {8'h00, e0});
      end
    end
    if (im_we1) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_write: got addr %0h data %0h expected no write", im_addr1, im_wdata1);
      end else begin
        e1 = exp1.pop_front();
        check("dut1_write", {8'h00, im_addr1, im_wdata1}, {8'h00, e1});
      end
    end
    check("status_exclusive", {29'd0, done0 & err0, (done0 | err0) & busy0, (done1 | err1) & busy1}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_start);
    int t;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    start      = mid_start;
    t = 0;
    forever begin
      @(negedge clk);
      if (byte_ready0) break;
      t++;
      if (t > 50) begin
        checks++; errors++;
        $display("FAIL byte_accept_timeout: got byte_ready=0 expected 1 for byte %0h", b);
        byte_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    tick();
    start = 1'b0;
  endtask

  function automatic int gap_for(input int mode, input int idx);
    if (mode == 1) return idx % 2;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic finish_frame(input bit exp_done, input string tag);
    int t;
    t = 0;
    while (!(done0 || err0) && t < 20) begin
      tick();
      t++;
    end
    check({tag, "_done0"}, {31'd0, done0}, {31'd0, exp_done});
    check({tag, "_err0"},  {31'd0, err0},  {31'd0, !exp_done});
    check({tag, "_done1"}, {31'd0, done1}, {31'd0, exp_done});
    check({tag, "_busy"},  {30'd0, busy0, busy1}, 32'd0);
    check({tag, "_ready"}, {30'd0, byte_ready0, byte_ready1}, 32'd0);
    check({tag, "_pending_writes"}, exp0.size() + exp1.size(), 32'd0);
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    int idx;
    logic [7:0] a1;
    idx = 0;
    start_pulse();
    check({tag, "_busy_after_start"}, {31'd0, busy0}, 32'd1);
    send_byte(f.n, gap_for(f.mode, idx), 1'b0);
    idx++;
    for (int w = 0; w < int'(f.n); w++) begin
      send_byte(f.words[w][15:8], gap_for(f.mode, idx), f.mid_start && idx == 2);
      idx++;
      a1 = 8'hFE + 8'(w);
      exp0.push_back({8'(w), f.words[w]});
      exp1.push_back({a1, f.words[w]});
      send_byte(f.words[w][7:0], gap_for(f.mode, idx), 1'b0);
      idx++;
    end
    send_byte(f.csum, gap_for(f.mode, idx), 1'b0);
    byte_valid = 1'b0;
    finish_frame(f.exp_done, tag);
  endtask

  initial begin
    tbl[0] = '{8'd2, {16'h0000, 16'h0000, 16'h6000, 16'h4105}, 8'h24, 0, 1'b0, 1'b1};
    tbl[1] = '{8'd2, {16'h0000, 16'h0000, 16'h6000, 16'h4105}, 8'h25, 0, 1'b0, 1'b0};
    tbl[2] = '{8'd3, {16'h0000, 16'h3333, 16'h2222, 16'h1111}, 8'h00, 0, 1'b0, 1'b1};
    tbl[3] = '{8'd2, {16'h0000, 16'h0000, 16'h6000, 16'h4105}, 8'h24, 1, 1'b1, 1'b1};
    tbl[4] = '{8'd1, {16'h0000, 16'h0000, 16'h0000, 16'hA55A}, 8'hFF, 2, 1'b0, 1'b1};
    tbl[5] = '{8'd3, {16'h0000, 16'h0506, 16'h0304, 16'h0102}, 8'h07, 2, 1'b1, 1'b1};
    tbl[6] = '{8'd4, {16'h7E7E, 16'h8001, 16'h0000, 16'hFFFF}, 8'h80, 1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) tick();
    check("reset_outputs0", {27'd0, byte_ready0, im_we0, busy0, done0, err0}, 32'd0);
    check("reset_addr0", {24'd0, im_addr0}, 32'h00);
    check("reset_addr1", {24'd0, im_addr1}, 32'hFE);
    check("reset_wdata", {im_wdata0, im_wdata1}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      $display("frame %0d: n=%0d csum=%0h mode=%0d", i, tbl[i].n, tbl[i].csum, tbl[i].mode);
      run_frame(tbl[i], $sformatf("frame%0d", i));
    end

    // Zero-length frame: immediate error, no writes, stream ignored afterwards.
    $display("zero-length frame");
    start_pulse();
    send_byte(8'h00, 0, 1'b0);
    check("zero_len_err", {29'd0, err0, done0, busy0}, 32'b100);
    byte_in = 8'h55;
    repeat (5) begin
      tick();
      check("zero_len_ready", {30'd0, byte_ready0, err0}, 32'b01);
    end
    byte_valid = 1'b0;

    // Reset after the high byte of the first word abandons the frame.
    $display("reset mid-load");
    start_pulse();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h41, 0, 1'b0);
    byte_in = 8'h05;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outputs", {27'd0, byte_ready0, im_we0, busy0, done0, err0}, 32'd0);
    check("midrst_addr", {16'd0, im_addr0, im_addr1}, 32'h00FE);
    check("midrst_wdata", {16'd0, im_wdata0}, 32'd0);
    repeat (4) begin
      tick();
      check("midrst_idle", {30'd0, byte_ready0, busy0}, 32'd0);
    end
    byte_valid = 1'b0;
    run_frame(tbl[0], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-serial program loader: the write side of the processor's instruction memory, the counterpart of the fetch path that reads 16-bit instruction words by PC.
- Receives a framed byte stream (length, instruction bytes, checksum) over a valid/ready handshake.
- Assembles 16-bit instructions and writes them to instruction memory at consecutive addresses.
- Reports done or error. Runs before the core is released from halt.

Parameters:
- ADDR_W, 8, instruction memory address width (matches the 8-bit PC).
- BASE_ADDR, 0, address of the first word written.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE, DONE, ERR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- im_addr  out  ADDR_W  instruction memory write address.
- im_wdata  out  16  instruction word; bits [15:11] are the opcode field.
- im_we  out  1  one-cycle write strobe.
- busy  out  1  load in progress.
- done  out  1  load completed, checksum good.
- err  out  1  load aborted: zero length or checksum mismatch.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0; im_addr=BASE_ADDR; internal count, checksum and high-byte registers cleared. Reset mid-load abandons the frame; no further im_we.
- Handshake: a byte is accepted on a cycle where byte_valid && byte_ready. byte_ready is a registered function of state: 1 only in LEN, HI, LO, CSUM.
- Frame format: byte0 = word count N (1..255). Then 2N bytes, each word high byte first. Then one checksum byte = XOR of all 2N data bytes (length byte excluded).
- States:
  - IDLE: start=1 -> LEN; busy=1, chk=0, im_addr=BASE_ADDR.
  - LEN: on accept, N=0 -> ERR; else cnt=N -> HI.
  - HI: on accept, hi=byte, chk^=byte -> LO.
  - LO: on accept, im_wdata={hi,byte}, chk^=byte -> WRITE.
  - WRITE: im_we=1 for exactly this cycle with im_addr and im_wdata stable; cnt decrements. Next state is CSUM if cnt becomes 0, else HI. im_addr increments on exit from WRITE.
  - CSUM: on accept, byte==chk -> DONE, else ERR.
  - DONE: done=1, busy=0; holds until start, which clears done and re-enters LEN as from IDLE.
  - ERR: err=1, busy=0; same exit rule as DONE.
- Latency: the LO-byte accept at cycle t gives im_we=1 at cycle t+1. byte_ready is 0 in WRITE, so words take a minimum of 3 cycles each.
- Address: increments modulo 2^ADDR_W. A frame with BASE_ADDR+N > 2^ADDR_W wraps to 0 without error.
- Writes already issued are not rolled back on checksum error.
- start is ignored while busy. byte_valid outside ready states is ignored and no byte is consumed.
- byte_in/byte_valid idle gaps of any length are allowed in every ready state.
- Exactly one of done/err may be 1, and never while busy=1.

Test Plan:
- BASE_ADDR=0, start, stream 02 41 05 60 00 24 -> im_we pulses twice: addr 0 data 0x4105, addr 1 data 0x6000. done=1, err=0, busy=0.
- Same frame with checksum 25 -> the two writes still occur; err=1, done=0.
- Length byte 00 -> no im_we; err=1 one cycle after accept; byte_ready=0 thereafter until start.
- BASE_ADDR=0xFE, N=3, words 0x1111 0x2222 0x3333, checksum 00 -> writes at FE, FF, 00; done=1.
- Throttle byte_valid on alternate cycles plus a back-to-back burst; assert start mid-load -> identical writes to the unthrottled case; start has no effect while busy.
- Assert rst after the HI byte of word 1 -> im_we never asserts; all outputs 0; state IDLE. A fresh start then loads correctly from BASE_ADDR.
